// File: rtl/mem_pkg.sv
// Shared constants, state encoding and helpers for mem_unit.
// MEM_CLEAR_EN adds the CLEAR state used by the post-reset memory sweep.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;

`ifdef MEM_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;
`else
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;
`endif

  // Wait counter width: enough to hold WAIT_CYCLES, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write port, combinational read port.
// Out-of-range addresses are ignored on write and read back as zero.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              waddr_ok_c;
  logic              raddr_ok_c;

  assign waddr_ok_c = ({1'b0, waddr} < (ADDR_W + 1)'(DEPTH));
  assign raddr_ok_c = ({1'b0, raddr} < (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (we && waddr_ok_c) begin
      mem_q[IDX_W'(waddr)] <= wdata;
    end
  end

  assign rdata = raddr_ok_c ? mem_q[IDX_W'(raddr)] : '0;

endmodule

// File: rtl/mem_unit.sv
// Bus-attached memory unit with MAR/MDR registers and configurable access latency.
// Define MEM_CLEAR_EN to sweep the memory to zero after every reset.
module mem_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              mem_rd,
  input  logic              mdr_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

`ifdef MEM_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic              mar_oor_c;
  logic              cmd_c;

  assign mar_oor_c = ({1'b0, mar_q} >= (ADDR_W + 1)'(DEPTH));
  assign cmd_c     = mar_in | mdr_in | mem_rd;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .wdata (mem_wdata_c),
    .raddr (mar_q),
    .rdata (mem_rdata_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= RST_BUSY;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MEM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Next-state, datapath updates and memory port control
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = mar_q;
    mem_wdata_c = mdr_q;
`ifdef MEM_CLEAR_EN
    clr_d       = clr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (mar_in) begin
          mar_d = bus_in[ADDR_W-1:0];
        end
        // A simultaneous write wins; the read is dropped and flagged.
        if (mdr_in) begin
          mdr_d   = bus_in;
          wr_d    = 1'b1;
          state_d = ST_ACCESS;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          err_d   = mem_rd;
        end else if (mem_rd) begin
          wr_d    = 1'b0;
          state_d = ST_ACCESS;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end

      ST_ACCESS: begin
        err_d = cmd_c;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (mar_oor_c) begin
            err_d = 1'b1;
          end
          if (wr_q) begin
            mem_we_c = !rst && !mar_oor_c;
          end else begin
            mdr_d = mar_oor_c ? '0 : mem_rdata_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef MEM_CLEAR_EN
      ST_CLEAR: begin
        err_d       = cmd_c;
        mem_we_c    = !rst;
        mem_waddr_c = clr_q;
        mem_wdata_c = '0;
        if (clr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus_out = mdr_q;
  assign bus_oe  = mdr_out;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_unit.sv
// Randomized self-checking bench for mem_unit: two instances (WAIT_CYCLES 0 and 2,
// DEPTH 200) share stimulus and are compared against a transaction-level model.
module tb_mem_unit;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned DEP = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          mar_in, mdr_in, mem_rd, mdr_out;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out [2];
  logic          bus_oe  [2];
  logic          busy    [2];
  logic          done    [2];
  logic          err     [2];

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] m_mem   [DEP];
  bit            m_known [DEP];
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr;
  bit            m_mdr_known;

  mem_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mar_in(mar_in), .mdr_in(mdr_in), .mem_rd(mem_rd),
    .mdr_out(mdr_out), .bus_in(bus_in), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  mem_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .mar_in(mar_in), .mdr_in(mdr_in), .mem_rd(mem_rd),
    .mdr_out(mdr_out), .bus_in(bus_in), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_mar       = '0;
    m_mdr       = '0;
    m_mdr_known = 1'b1;
`ifdef MEM_CLEAR_EN
    for (int a = 0; a < int'(DEP); a++) begin
      m_mem[a]   = '0;
      m_known[a] = 1'b1;
    end
`endif
  endtask

`ifdef MEM_CLEAR_EN
  // Sweep in progress: busy for DEP samples, one command dropped with err.
  task automatic wait_clear();
    for (int j = 0; j < int'(DEP); j++) begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i] !== 1'b1) begin
          nerr++; $display("FAIL clear_busy dut%0d j=%0d got %b exp 1", i, j, busy[i]);
        end
        nvec++;
        if (done[i] !== 1'b0) begin
          nerr++; $display("FAIL clear_done dut%0d j=%0d got %b exp 0", i, j, done[i]);
        end
        nvec++;
        if (err[i] !== (j == 4)) begin
          nerr++; $display("FAIL clear_err dut%0d j=%0d got %b exp %b", i, j, err[i], (j == 4));
        end
        nvec++;
      end
      if (j == 3) begin
        mar_in = 1'b1;
        bus_in = 16'd99;
      end
      tick();
      mar_in = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (busy[i] !== 1'b0) begin
        nerr++; $display("FAIL clear_end dut%0d got %b exp 0", i, busy[i]);
      end
      nvec++;
    end
  endtask
`endif

  task automatic set_mar(input logic [AW-1:0] a);
    mar_in  = 1'b1;
    bus_in  = DW'(a);
    mdr_out = 1'($urandom_range(0, 1));
    tick();
    mar_in = 1'b0;
    m_mar  = a;
    for (int i = 0; i < 2; i++) begin
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || err[i] !== 1'b0) begin
        nerr++; $display("FAIL set_mar_flags dut%0d got busy=%b done=%b err=%b exp 000",
                         i, busy[i], done[i], err[i]);
      end
      nvec++;
      if (m_mdr_known && bus_out[i] !== m_mdr) begin
        nerr++; $display("FAIL set_mar_mdr dut%0d got %h exp %h", i, bus_out[i], m_mdr);
      end
      nvec++;
    end
  endtask

  // One access; intr: 0 none, 1 mar_in, 2 mdr_in, 3 mem_rd injected while busy.
  task automatic access(input bit wr, input bit rd, input bit with_mar,
                        input logic [DW-1:0] bus, input int intr);
    logic [AW-1:0] addr;
    logic [DW-1:0] old_v, new_v, e_bus;
    bit            oor, both, old_k, new_k, e_k, e_busy, e_done, e_err;
    int            w;
    if (with_mar) m_mar = bus[AW-1:0];
    addr  = m_mar;
    oor   = (int'(addr) >= int'(DEP));
    both  = wr && rd;
    old_v = m_mdr;
    old_k = m_mdr_known;
    if (wr) begin
      new_v = bus; new_k = 1'b1;
    end else if (oor) begin
      new_v = '0;  new_k = 1'b1;
    end else begin
      new_v = m_mem[int'(addr)]; new_k = m_known[int'(addr)];
    end

    mar_in  = with_mar;
    mdr_in  = wr;
    mem_rd  = rd;
    bus_in  = bus;
    mdr_out = 1'($urandom_range(0, 1));
    tick();
    mar_in = 1'b0; mdr_in = 1'b0; mem_rd = 1'b0;

    for (int k = 0; k <= 4; k++) begin
      for (int i = 0; i < 2; i++) begin
        w      = wait_of(i);
        e_busy = (k <= w);
        e_done = (k == w + 1);
        e_err  = (both && k == 0) || (intr != 0 && k == 1) || (oor && k == w + 1);
        if (wr)          begin e_bus = bus;   e_k = 1'b1;  end
        else if (k <= w) begin e_bus = old_v; e_k = old_k; end
        else             begin e_bus = new_v; e_k = new_k; end
        if (busy[i] !== e_busy) begin
          nerr++; $display("FAIL busy dut%0d a=%0d k=%0d got %b exp %b", i, addr, k, busy[i], e_busy);
        end
        nvec++;
        if (done[i] !== e_done) begin
          nerr++; $display("FAIL done dut%0d a=%0d k=%0d got %b exp %b", i, addr, k, done[i], e_done);
        end
        nvec++;
        if (err[i] !== e_err) begin
          nerr++; $display("FAIL err dut%0d a=%0d k=%0d got %b exp %b", i, addr, k, err[i], e_err);
        end
        nvec++;
        if (bus_oe[i] !== mdr_out) begin
          nerr++; $display("FAIL bus_oe dut%0d k=%0d got %b exp %b", i, k, bus_oe[i], mdr_out);
        end
        nvec++;
        if (e_k) begin
          if (bus_out[i] !== e_bus) begin
            nerr++; $display("FAIL mdr dut%0d a=%0d k=%0d wr=%0b got %h exp %h",
                             i, addr, k, wr, bus_out[i], e_bus);
          end
          nvec++;
        end
      end
      if (k == 0 && intr != 0) begin
        mar_in = (intr == 1);
        mdr_in = (intr == 2);
        mem_rd = (intr == 3);
        bus_in = DW'($urandom);
      end
      if (k < 4) begin
        mdr_out = 1'($urandom_range(0, 1));
        tick();
        mar_in = 1'b0; mdr_in = 1'b0; mem_rd = 1'b0;
      end
    end

    if (wr && !oor) begin
      m_mem[int'(addr)]   = bus;
      m_known[int'(addr)] = 1'b1;
    end
    m_mdr       = new_v;
    m_mdr_known = new_k;
  endtask

  task automatic test_reset();
    rst = 1'b1; mar_in = 1'b0; mdr_in = 1'b0; mem_rd = 1'b0; mdr_out = 1'b0; bus_in = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
`ifdef MEM_CLEAR_EN
      if (busy[i] !== 1'b1) begin
`else
      if (busy[i] !== 1'b0) begin
`endif
        nerr++; $display("FAIL reset_busy dut%0d got %b", i, busy[i]);
      end
      nvec++;
      if (done[i] !== 1'b0 || err[i] !== 1'b0) begin
        nerr++; $display("FAIL reset_pulses dut%0d got done=%b err=%b exp 00", i, done[i], err[i]);
      end
      nvec++;
      if (bus_out[i] !== '0) begin
        nerr++; $display("FAIL reset_mdr dut%0d got %h exp 0000", i, bus_out[i]);
      end
      nvec++;
    end
    model_reset();
`ifdef MEM_CLEAR_EN
    wait_clear();
`endif
  endtask

  task automatic test_basic();
    set_mar(8'd42);
    access(1'b1, 1'b0, 1'b0, 16'd21, 0);
    access(1'b0, 1'b1, 1'b0, 16'hFFFF, 0);
    mdr_out = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (bus_out[i] !== 16'd21 || bus_oe[i] !== 1'b1) begin
        nerr++; $display("FAIL basic_drive dut%0d got %h/%b exp 0015/1", i, bus_out[i], bus_oe[i]);
      end
      nvec++;
    end
    set_mar(8'd32); access(1'b1, 1'b0, 1'b0, 16'd24, 0);
    set_mar(8'd33); access(1'b1, 1'b0, 1'b0, 16'd25, 0);
    set_mar(8'd32); access(1'b0, 1'b1, 1'b0, 16'h0, 0);
    set_mar(8'd33); access(1'b0, 1'b1, 1'b0, 16'h0, 0);
    set_mar(8'd0);  access(1'b1, 1'b0, 1'b0, 16'h1234, 0);
    // MAR load and read in the same cycle must use the new address.
    access(1'b0, 1'b1, 1'b1, 16'd42, 0);
    set_mar(8'd199); access(1'b1, 1'b0, 1'b0, 16'hA5C3, 0);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
  endtask

  task automatic test_out_of_range();
    set_mar(8'd210);
    access(1'b1, 1'b0, 1'b0, 16'hBEEF, 0);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
    set_mar(8'd200);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
    set_mar(8'd42);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
  endtask

  task automatic test_busy_cmds();
    set_mar(8'd33);
    access(1'b0, 1'b1, 1'b0, 16'h0, 1);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
    access(1'b1, 1'b0, 1'b0, 16'h7777, 2);
    access(1'b0, 1'b1, 1'b0, 16'h0, 3);
  endtask

  task automatic test_both_strobes();
    set_mar(8'd50);
    access(1'b1, 1'b1, 1'b0, 16'h4242, 0);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: set_mar(AW'($urandom_range(0, 219)));
        1: access(1'b1, 1'b0, 1'b0, DW'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
        2: access(1'b0, 1'b1, 1'b0, DW'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
        3: access(1'b0, 1'b1, 1'b1, DW'($urandom_range(0, 219)), 0);
        default: access(1'b1, 1'($urandom_range(0, 1)), 1'b1, DW'($urandom_range(0, 219)), 0);
      endcase
    end
  endtask

  task automatic test_reset_abort();
    set_mar(8'd32);
    mdr_in = 1'b1;
    bus_in = 16'h5A5A;
    tick();
    mdr_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (busy[i] !== 1'b1 || bus_out[i] !== 16'h5A5A) begin
        nerr++; $display("FAIL abort_start dut%0d got busy=%b mdr=%h exp 1/5a5a", i, busy[i], bus_out[i]);
      end
      nvec++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (done[i] !== 1'b0 || err[i] !== 1'b0 || bus_out[i] !== '0) begin
        nerr++; $display("FAIL abort_reset dut%0d got done=%b err=%b mdr=%h exp 0/0/0000",
                         i, done[i], err[i], bus_out[i]);
      end
      nvec++;
    end
    model_reset();
`ifdef MEM_CLEAR_EN
    wait_clear();
`else
    for (int j = 0; j < 3; j++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (done[i] !== 1'b0 || busy[i] !== 1'b0) begin
          nerr++; $display("FAIL abort_quiet dut%0d j=%0d got done=%b busy=%b exp 00", i, j, done[i], busy[i]);
        end
        nvec++;
      end
    end
`endif
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
    set_mar(8'd32);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
  endtask

`ifdef MEM_CLEAR_EN
  task automatic test_clear();
    set_mar(8'd5);
    access(1'b1, 1'b0, 1'b0, 16'd7, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    wait_clear();
    set_mar(8'd5);
    access(1'b0, 1'b1, 1'b0, 16'h0, 0);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d vectors", nvec);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < int'(DEP); a++) begin
      m_mem[a]   = '0;
      m_known[a] = 1'b0;
    end
    test_reset();
    test_basic();
    test_out_of_range();
    test_busy_cmds();
    test_both_strobes();
    test_random();
    test_reset_abort();
`ifdef MEM_CLEAR_EN
    test_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
